multicycle_control_fsm: RTL and testbench

//  Multicycle controller driving multicycle_computer_datapath_verilog's control inputs from INSTRUCTION_OUT/FLAGS.

---
 rtl/mc_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_cond_check.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, select codes, condition codes and ALU-op decode for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    // ALUop codes
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_ORR = 3'b011;
    localparam logic [2:0] ALUOP_MOV = 3'b100;

    // ShiftType: 111 means no shift applied
    localparam logic [2:0] SHIFT_NONE = 3'b111;

    // ResultSrc codes
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_DFLT = 2'b10;

    // ALUSrcA / ALUSrcB / RegSrc codes
    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RN   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_BR   = 2'b10;
    localparam logic [1:0] SRCB_DFLT = 2'b11;
    localparam logic [1:0] REGSRC_DFLT = 2'b10;

    // Instruction classes (I[27:26])
    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands that get a dedicated ALUop
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    function automatic logic [2:0] alu_op_of(input logic [3:0] cmd);
        case (cmd)
            CMD_AND: return ALUOP_AND;
            CMD_SUB: return ALUOP_SUB;
            CMD_ADD: return ALUOP_ADD;
            CMD_ORR: return ALUOP_ORR;
            CMD_CMP: return ALUOP_SUB;
            CMD_MOV: return ALUOP_MOV;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_cond_check.sv
// rtl/mc_cond_check.sv - condition field versus {N,Z,C,V} flags, combinational pass/fail
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Evaluate the condition; 1111 never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle datapath controller with cond gating, run/step control and retire counter
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16,
    parameter bit STEP_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic [3:0]         FLAGS,
    input  logic               run,
    input  logic               step,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic               A3Src,
    output logic               WD3Src,
    output logic               FlagUpdate,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         RegSrc,
    output logic [2:0]         ALUop,
    output logic [2:0]         ShiftType,
    output logic               halted,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count
);

    localparam state_t RESET_STATE = STEP_EN ? IDLE : FETCH;

    state_t state, state_next;
    logic   retire;

    logic [31:0] ir;
    assign ir = INSTRUCTION[31:0];

    logic [1:0] op;
    logic       imm, sl, link, rd_pc, is_cmp;
    logic [3:0] cmd;
    assign op     = ir[27:26];
    assign imm    = ir[25];
    assign cmd    = ir[24:21];
    assign sl     = ir[20];
    assign link   = ir[24];
    assign rd_pc  = (ir[15:12] == 4'hF);
    assign is_cmp = (cmd == CMD_CMP);

    logic cond_pass, exec_ok;
    mc_cond_check u_cond (
        .cond  (ir[31:28]),
        .flags (FLAGS),
        .pass  (cond_pass)
    );
    // Undefined class 11 is squashed exactly like a failed condition
    assign exec_ok = cond_pass && (op != 2'b11);

    // Where to go after an instruction finishes: keep running or park
    state_t after_instr;
    assign after_instr = (!STEP_EN || run) ? FETCH : IDLE;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    // Retired-instruction counter; squashed instructions are not counted
    always_ff @(posedge clock) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (run || step) state_next = FETCH;
            FETCH:    state_next = DECODE;
            DECODE: begin
                if (!exec_ok)           state_next = after_instr;
                else if (op == OP_MEM)  state_next = MEMADR;
                else if (op == OP_ALU)  state_next = imm ? EXECI : EXECR;
                else                    state_next = BRANCH;
            end
            MEMADR:   state_next = sl ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECR,
            EXECI:    state_next = is_cmp ? after_instr : ALUWB;
            MEMWB,
            MEMWRITE,
            ALUWB,
            BRANCH:   state_next = after_instr;
            default:  state_next = RESET_STATE;
        endcase
    end

    // Output decode: one case on the state register, registered IR as the only other input
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        A3Src      = 1'b0;
        WD3Src     = 1'b0;
        FlagUpdate = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_DFLT;
        ResultSrc  = RES_DFLT;
        RegSrc     = REGSRC_DFLT;
        ALUop      = ALUOP_ADD;
        ShiftType  = SHIFT_NONE;
        halted     = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE:  halted = 1'b1;
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RN;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                ALUSrcA = SRCA_RN;
                ALUSrcB = SRCB_IMM;
            end
            MEMWB: begin
                AdrSrc    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
                PCWrite   = rd_pc;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                ALUSrcA  = SRCA_RN;
                ALUSrcB  = SRCB_IMM;
                retire   = 1'b1;
            end
            EXECR, EXECI: begin
                ALUSrcA    = SRCA_RN;
                ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                ShiftType  = (state == EXECI) ? SHIFT_NONE : ir[6:4];
                ALUop      = alu_op_of(cmd);
                FlagUpdate = sl || is_cmp;
                retire     = is_cmp;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_ALU;
                ALUop     = alu_op_of(cmd);
                PCWrite   = rd_pc;
                retire    = 1'b1;
            end
            BRANCH: begin
                ALUSrcB  = SRCB_BR;
                PCWrite  = 1'b1;
                RegWrite = link;
                A3Src    = link;
                WD3Src   = link;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_done = retire || ((state == DECODE) && !exec_ok);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized and directed checks of the multicycle controller against an instruction-level model
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic pcw, irw, rw, mw, adr, a3, wd3, fu;
        logic [1:0] sa, sb, rs, rg;
        logic [2:0] op, sh;
        logic done, halt;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: STEP_EN=1, CNT_W=16 ----------------
    logic        rst_a = 1'b1;
    logic [31:0] ir_a = 32'h0, prog_a = 32'h0;
    logic [3:0]  flags_a = 4'h0;
    logic        run = 1'b0, step = 1'b0;
    logic pcw_a, irw_a, rw_a, mw_a, adr_a, a3_a, wd3_a, fu_a, halted_a, done_a;
    logic [1:0] sa_a, sb_a, rs_a, rg_a;
    logic [2:0] op_a, sh_a;
    logic [15:0] count_a;
    logic [15:0] cnt_a = 16'd0;

    multicycle_control_fsm #(.INSTR_W(32), .CNT_W(16), .STEP_EN(1'b1)) dut_a (
        .clock(clk), .reset(rst_a), .INSTRUCTION(ir_a), .FLAGS(flags_a),
        .run(run), .step(step),
        .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a),
        .AdrSrc(adr_a), .A3Src(a3_a), .WD3Src(wd3_a), .FlagUpdate(fu_a),
        .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ResultSrc(rs_a), .RegSrc(rg_a),
        .ALUop(op_a), .ShiftType(sh_a),
        .halted(halted_a), .instr_done(done_a), .instr_count(count_a)
    );

    ctl_t oa;
    assign oa = {pcw_a, irw_a, rw_a, mw_a, adr_a, a3_a, wd3_a, fu_a,
                 sa_a, sb_a, rs_a, rg_a, op_a, sh_a, done_a, halted_a};

    // Instruction register stand-in for the datapath
    always @(posedge clk) if (irw_a) ir_a <= prog_a;

    // ---------------- instance B: STEP_EN=0, CNT_W=2 ----------------
    logic        rst_b = 1'b1;
    logic [31:0] ir_b = 32'h0;
    logic [31:0] prog_b = 32'hE2800001;
    logic pcw_b, irw_b, rw_b, mw_b, adr_b, a3_b, wd3_b, fu_b, halted_b, done_b;
    logic [1:0] sa_b, sb_b, rs_b, rg_b;
    logic [2:0] op_b, sh_b;
    logic [1:0] count_b;

    multicycle_control_fsm #(.INSTR_W(32), .CNT_W(2), .STEP_EN(1'b0)) dut_b (
        .clock(clk), .reset(rst_b), .INSTRUCTION(ir_b), .FLAGS(4'h0),
        .run(1'b0), .step(1'b0),
        .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b),
        .AdrSrc(adr_b), .A3Src(a3_b), .WD3Src(wd3_b), .FlagUpdate(fu_b),
        .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ResultSrc(rs_b), .RegSrc(rg_b),
        .ALUop(op_b), .ShiftType(sh_b),
        .halted(halted_b), .instr_done(done_b), .instr_count(count_b)
    );

    always @(posedge clk) if (irw_b) ir_b <= prog_b;

    // ---------------- reference model ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t dflt();
        ctl_t c = '0;
        c.sb = 2'b11; c.rs = 2'b10; c.rg = 2'b10; c.sh = 3'b111;
        return c;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c = dflt();
        c.halt = 1'b1;
        return c;
    endfunction

    function automatic bit cond_ok(input logic [3:0] cnd, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (cnd)
            4'h0: return z;              4'h1: return !z;
            4'h2: return cy;             4'h3: return !cy;
            4'h4: return n;              4'h5: return !n;
            4'h6: return v;              4'h7: return !v;
            4'h8: return cy && !z;       4'h9: return !cy || z;
            4'hA: return n == v;         4'hB: return n != v;
            4'hC: return !z && n == v;   4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(input logic [3:0] cmd);
        case (cmd)
            4'b0000: return 3'b010;
            4'b0010: return 3'b001;
            4'b0100: return 3'b000;
            4'b1100: return 3'b011;
            4'b1010: return 3'b001;
            4'b1101: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Executes one instruction on instance A: builds the cycle-by-cycle expectation for the
    // whole instruction, starts it (step pulse or already-running), then checks every cycle.
    // Returns at the negedge of the instruction's final cycle.
    task automatic exec_one(input logic [31:0] ins, input logic [3:0] fl,
                            input bit use_step, input int drop_at);
        ctl_t q[$];
        ctl_t c;
        bit   ret = 1'b0;
        logic [1:0] op = ins[27:26];
        logic [3:0] cmd = ins[24:21];
        logic       sl = ins[20];
        logic       rd15 = (ins[15:12] == 4'hF);
        logic       link = ins[24];
        logic       is_cmp = (ins[24:21] == 4'b1010);

        c = dflt(); c.irw = 1'b1; c.pcw = 1'b1; q.push_back(c);
        c = dflt();
        if (!cond_ok(ins[31:28], fl) || op == 2'b11) begin
            c.done = 1'b1; q.push_back(c);
        end else begin
            q.push_back(c);
            ret = 1'b1;
            if (op == 2'b01) begin
                c = dflt(); c.sa = 2'b01; c.sb = 2'b01; q.push_back(c);
                if (sl) begin
                    c = dflt(); c.adr = 1'b1; c.sa = 2'b01; c.sb = 2'b01; q.push_back(c);
                    c = dflt(); c.adr = 1'b1; c.rw = 1'b1; c.rs = 2'b01; c.pcw = rd15; c.done = 1'b1;
                    q.push_back(c);
                end else begin
                    c = dflt(); c.adr = 1'b1; c.mw = 1'b1; c.sa = 2'b01; c.sb = 2'b01; c.done = 1'b1;
                    q.push_back(c);
                end
            end else if (op == 2'b00) begin
                c = dflt(); c.sa = 2'b01;
                c.sb = ins[25] ? 2'b01 : 2'b00;
                c.sh = ins[25] ? 3'b111 : ins[6:4];
                c.op = alu_ref(cmd); c.fu = sl | is_cmp; c.done = is_cmp;
                q.push_back(c);
                if (!is_cmp) begin
                    c = dflt(); c.rw = 1'b1; c.rs = 2'b00; c.op = alu_ref(cmd); c.pcw = rd15; c.done = 1'b1;
                    q.push_back(c);
                end
            end else begin
                c = dflt(); c.sb = 2'b10; c.pcw = 1'b1;
                c.rw = link; c.a3 = link; c.wd3 = link; c.done = 1'b1;
                q.push_back(c);
            end
        end

        prog_a = ins;
        if (use_step) step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        flags_a = fl;
        foreach (q[i]) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("ins=%h cyc%0d ctl", ins, i), 32'(oa), 32'(q[i]));
            if (i == drop_at) run = 1'b0;
        end
        if (ret) cnt_a = cnt_a + 16'd1;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, " idle ctl"}, 32'(oa), 32'(idle_ctl()));
        chk({tag, " count"}, 32'(count_a), 32'(cnt_a));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 1) == 1) w[31:28] = 4'hE;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] seq_b [5];
        int k;
        bit pend;
        bit stayed_busy;
        seq_b[0] = 2'd1; seq_b[1] = 2'd2; seq_b[2] = 2'd3; seq_b[3] = 2'd0; seq_b[4] = 2'd1;

        repeat (3) @(negedge clk);
        chk("reset A ctl", 32'(oa), 32'(idle_ctl()));
        chk("reset A count", 32'(count_a), 32'd0);
        chk("reset B halted", 32'(halted_b), 32'd0);
        rst_a = 1'b0;
        @(negedge clk);
        chk("idle A holds", 32'(oa), 32'(idle_ctl()));

        // T1: LDR R1,[R0,#4] single step
        exec_one(32'hE5901004, 4'h0, 1'b1, -1);
        idle_chk("T1");

        // T2: ADDS, then BEQ taken, then BEQ squashed
        exec_one(32'hE2900001, 4'h0, 1'b1, -1);
        idle_chk("T2 adds");
        exec_one(32'h0A000000, 4'b0110, 1'b1, -1);
        idle_chk("T2 beq taken");
        exec_one(32'h0A000000, 4'b0010, 1'b1, -1);
        idle_chk("T2 beq squash");

        // T3: CMP R0,R1 with equal operands
        exec_one(32'hE1500001, 4'b0110, 1'b1, -1);
        idle_chk("T3");

        // T4: run stream, run dropped during the second instruction
        run = 1'b1;
        exec_one(32'hE2800001, 4'h0, 1'b0, -1);
        exec_one(32'hE0810002, 4'h0, 1'b0, 1);
        idle_chk("T4");

        // Random single-step instructions
        for (int i = 0; i < 30; i++) begin
            exec_one(rand_instr(), 4'($urandom_range(0, 15)), 1'b1, -1);
            idle_chk("rand step");
        end

        // Random continuous run, with step pulses ignored while running
        run = 1'b1;
        for (int i = 0; i < 30; i++)
            exec_one(rand_instr(), 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1), (i == 29) ? 1 : -1);
        idle_chk("rand run");

        // T5: reset while in MEMREAD
        prog_a = 32'hE5901004;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("T5 in MEMREAD adr", 32'(adr_a), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        cnt_a = 16'd0;
        chk("T5 after reset ctl", 32'(oa), 32'(idle_ctl()));
        chk("T5 after reset count", 32'(count_a), 32'd0);
        rst_a = 1'b0;
        @(negedge clk);
        chk("T5 no strobes after", 32'(oa), 32'(idle_ctl()));

        // T6: free-running instance with 2-bit counter
        rst_b = 1'b0;
        k = 0;
        pend = 1'b0;
        stayed_busy = 1'b1;
        for (int cyc = 0; cyc < 200 && k < 5; cyc++) begin
            @(negedge clk);
            if (halted_b !== 1'b0) stayed_busy = 1'b0;
            if (pend) begin
                chk($sformatf("T6 count #%0d", k), 32'(count_b), 32'(seq_b[k]));
                k++;
                pend = 1'b0;
            end
            if (done_b) pend = 1'b1;
        end
        chk("T6 retirements seen", k, 5);
        chk("T6 never halted", 32'(stayed_busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
